ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_if.sv | 26 ++
 rtl/ram_bist_ctrl.sv | 97 +++++++++
 tb/tb_ram_bist_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// ram_bist_if: start/seed request, RAM port and result signals of the BIST controller
interface ram_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] seed;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_WIDTH+1:0] err_count;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [DATA_WIDTH-1:0] fail_data;
  modport master (
    input  start, seed, ram_dout,
    output ram_we, ram_addr, ram_din, busy, done, pass, err_count, fail_addr, fail_data
  );
  modport slave (
    output start, seed, ram_dout,
    input  ram_we, ram_addr, ram_din, busy, done, pass, err_count, fail_addr, fail_data
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read/write-inverse/read-descending RAM test with a one-stage compare pipeline
module ram_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  ram_bist_if.master bus
);
  localparam int EW = ADDR_WIDTH + 2;
  typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d, pa_q, fa_q, fa_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d, din_q, din_d, pat_d, pat_q, pe_q, pe_d, fd_q, fd_d;
  logic [EW-1:0] err_q, err_d;
  logic we_q, we_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d, pv_q, pv_d;
  logic clr, miss, first;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    seed_d = seed_q;
    clr = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        state_d = W0;
        cnt_d = '0;
        seed_d = bus.seed;
        clr = 1'b1;
      end
      FLUSH: state_d = DONE;
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = (state_q == W0) ? R0 : (state_q == R0) ? W1 : (state_q == W1) ? R1 : FLUSH;
      end
    endcase
    // all outputs are registered, so they are derived from the next state
    addr_d = (state_d == R1) ? ~cnt_d : (state_d inside {W0, R0, W1}) ? cnt_d : '0;
    pat_d = seed_d ^ DATA_WIDTH'(addr_d);
    we_d = state_d inside {W0, W1};
    din_d = (state_d == W0) ? pat_d : (state_d == W1) ? ~pat_d : '0;
    pat_q = seed_q ^ DATA_WIDTH'(addr_q);
    pv_d = state_q inside {R0, R1};
    pe_d = (state_q == R1) ? ~pat_q : pat_q;
    miss = pv_q && (bus.ram_dout != pe_q);
    first = miss && (err_q == '0);
    err_d = clr ? '0 : (miss && !(&err_q)) ? err_q + 1'b1 : err_q;
    fa_d = clr ? '0 : first ? pa_q : fa_q;
    fd_d = clr ? '0 : first ? bus.ram_dout : fd_q;
    busy_d = state_d inside {W0, R0, W1, R1, FLUSH};
    done_d = state_d == DONE;
    pass_d = done_d && (err_d == '0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      seed_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= 1'b0;
      pv_q <= 1'b0;
      pa_q <= '0;
      pe_q <= '0;
      err_q <= '0;
      fa_q <= '0;
      fd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      seed_q <= seed_d;
      addr_q <= addr_d;
      din_q <= din_d;
      we_q <= we_d;
      pv_q <= pv_d;
      pa_q <= addr_q;
      pe_q <= pe_d;
      err_q <= err_d;
      fa_q <= fa_d;
      fd_q <= fd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
  assign bus.ram_we = we_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din = din_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_addr = fa_q;
  assign bus.fail_data = fd_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: RAM model plus a run-position model of the BIST, checked every cycle
module tb_ram_bist_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  int t = -1;
  int run_id = 0;
  int fault = 0;
  logic [7:0] mem [16];
  logic [7:0] m_seed = '0;
  int m_err = 0;
  logic [3:0] m_fa = '0;
  logic [7:0] m_fd = '0;
  logic pv = 1'b0;
  logic [3:0] pa = '0;
  logic [7:0] pexp = '0;
  logic [7:0] pgot = '0;
  ram_bist_if bus ();
  ram_bist_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // t = edges since the accepting edge: 0..15 W0, 16..31 R0, 32..47 W1, 48..63 R1, 64 FLUSH, 65 DONE
  function automatic logic [3:0] maddr(int tt);
    if (tt < 0 || tt > 63) return 4'd0;
    return (tt / 16 == 3) ? 4'(15 - tt % 16) : 4'(tt % 16);
  endfunction
  function automatic logic [7:0] mpat(int tt);
    logic [7:0] p;
    p = m_seed ^ {4'b0, maddr(tt)};
    if (tt < 0 || tt > 63) return 8'h00;
    return (tt / 16 == 0) ? p : (tt / 16 == 2) ? ~p : 8'h00;
  endfunction
  // fault 1: bit0 stuck low at addr 5; fault 2: reads return 00 during the descending pass
  function automatic logic [7:0] fx(logic [7:0] v, logic [3:0] a, int tt);
    if (fault == 1 && a == 4'd5) return v & 8'hFE;
    if (fault == 2 && tt >= 48 && tt < 64) return 8'h00;
    return v;
  endfunction
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= fx(mem[bus.ram_addr], bus.ram_addr, t);
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t <= -1;
      m_err <= 0;
      m_fa <= '0;
      m_fd <= '0;
      pv <= 1'b0;
    end else begin
      if (pv && pgot != pexp) begin
        if (m_err == 0) begin
          m_fa <= pa;
          m_fd <= pgot;
        end
        if (m_err < 63) m_err <= m_err + 1;
      end
      pv <= 1'b0;
      if ((t < 0 || t >= 65) && bus.start) begin
        t <= 0;
        m_seed <= bus.seed;
        m_err <= 0;
        m_fa <= '0;
        m_fd <= '0;
      end else if (t >= 0 && t < 65) t <= t + 1;
      if ((t >= 16 && t < 32) || (t >= 48 && t < 64)) begin
        pv <= 1'b1;
        pa <= maddr(t);
        pexp <= (t < 32) ? (m_seed ^ {4'b0, maddr(t)}) : ~(m_seed ^ {4'b0, maddr(t)});
        pgot <= fx(mem[maddr(t)], maddr(t), t);
      end
    end
  end
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d run=%0d)", nm, got, exp, t, run_id);
    end
  endtask
  always begin
    @(negedge clk or posedge rst);
    #1;
    if (rst) begin
      chk("rst_we", bus.ram_we, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_din", bus.ram_din, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pass", bus.pass, 0);
      chk("rst_err", bus.err_count, 0);
      chk("rst_faddr", bus.fail_addr, 0);
      chk("rst_fdata", bus.fail_data, 0);
    end else begin
      chk("we", bus.ram_we, (t >= 0 && t < 64 && (t / 16) % 2 == 0));
      chk("addr", bus.ram_addr, maddr(t));
      chk("din", bus.ram_din, mpat(t));
      chk("busy", bus.busy, (t >= 0 && t <= 64));
      chk("done", bus.done, (t >= 65));
      chk("pass", bus.pass, (t >= 65 && m_err == 0));
      chk("err_count", bus.err_count, m_err);
      chk("fail_addr", bus.fail_addr, m_fa);
      chk("fail_data", bus.fail_data, m_fd);
      if (run_id == 1 && t == 3) chk("lit_w0_a3", bus.ram_din, 8'hA6);
      if (run_id == 1 && t == 35) chk("lit_w1_a3", bus.ram_din, 8'h59);
      if ((run_id == 1 || run_id == 2 || run_id == 4 || run_id == 6) && t == 65) begin
        chk("lit_pass", bus.pass, 1);
        chk("lit_err0", bus.err_count, 0);
      end
      if (run_id == 2 && t == 64) chk("lit_done_64", bus.done, 0);
      if (run_id == 3 && t == 65) begin
        chk("lit_stuck_err", bus.err_count, 1);
        chk("lit_stuck_faddr", bus.fail_addr, 5);
        chk("lit_stuck_fdata", bus.fail_data, 8'h5E);
        chk("lit_stuck_pass", bus.pass, 0);
      end
      if (run_id == 4 && t == 0) chk("lit_clr_on_accept", bus.err_count, 0);
      if (run_id == 5 && t == 65) begin
        chk("lit_zero_err", bus.err_count, 16);
        chk("lit_zero_faddr", bus.fail_addr, 4'hF);
        chk("lit_zero_fdata", bus.fail_data, 8'h00);
      end
    end
  end
  task automatic wait_t(int target);
    for (int i = 0; i < 300 && t != target; i++) @(negedge clk);
    if (t != target) begin
      $display("FAIL timeout waiting for t=%0d", target);
      $fatal(1);
    end
  endtask
  task automatic launch(int id, logic [7:0] s, int f);
    @(negedge clk);
    fault = f;
    bus.seed = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_id = id;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.seed = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    launch(1, 8'hA5, 0);
    wait_t(65);
    repeat (3) @(negedge clk);
    launch(2, 8'hA5, 0);
    wait_t(20);
    bus.start = 1'b1;
    bus.seed = 8'h3C;
    @(negedge clk);
    bus.start = 1'b0;
    wait_t(65);
    @(negedge clk);
    launch(3, 8'hA5, 1);
    wait_t(65);
    @(negedge clk);
    launch(4, 8'hA5, 0);
    wait_t(65);
    @(negedge clk);
    launch(5, 8'h00, 2);
    wait_t(65);
    @(negedge clk);
    launch(6, 8'hA5, 0);
    wait_t(39);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    launch(6, 8'hA5, 0);
    wait_t(65);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
